// File: rtl/counter_ctrl_pkg.sv
// Shared types for the counter ramp controller: FSM state encoding and
// the step direction encoding used between controller and counter.
package counter_ctrl_pkg;

  typedef enum logic [1:0] {
    RAMP_IDLE,
    RAMP_RUN,
    RAMP_DONE
  } ramp_state_e;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/updown_sat_counter.sv
// Up/down counter that moves one LSB per enabled cycle and saturates
// at 0 and MaxValue instead of wrapping.
module updown_sat_counter
  import counter_ctrl_pkg::*;
#(
  parameter int Width    = 8,
  parameter int MaxValue = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  output logic [Width-1:0] count
);

  localparam logic [Width-1:0] MAX_V = Width'(MaxValue);

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (en) begin
      if (up == DIR_UP) begin
        if (count_q < MAX_V) count_d = count_q + 1'b1;
      end else begin
        if (count_q != '0) count_d = count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/counter_ramp_ctrl.sv
// Ramp sequencer: accepts a target/dwell command and walks the owned
// saturating counter toward the target one LSB per (dwell+1) cycles.
module counter_ramp_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter int Width      = 8,
  parameter int MaxValue   = 255,
  parameter int DwellWidth = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [Width-1:0]      cmd_target,
  input  logic [DwellWidth-1:0] cmd_dwell,
  input  logic                  abort,
  output logic [Width-1:0]      count,
  output logic                  busy,
  output logic                  done,
  output logic                  aborted,
  output logic                  err_range
);

  localparam logic [Width-1:0] MAX_V = Width'(MaxValue);

  ramp_state_e           state_q, state_d;
  logic [Width-1:0]      tgt_q, tgt_d;
  logic [DwellWidth-1:0] dwell_q, dwell_d;
  logic [DwellWidth-1:0] timer_q, timer_d;
  logic                  cmd_ready_q, cmd_ready_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  aborted_q, aborted_d;
  logic                  err_range_q, err_range_d;
  logic                  step_en;
  logic                  dir;
  logic [Width-1:0]      next_count;

  updown_sat_counter #(
    .Width    (Width),
    .MaxValue (MaxValue)
  ) u_counter (
    .clk   (clk),
    .rst   (rst),
    .en    (step_en),
    .up    (dir),
    .count (count)
  );

  always_comb begin
    state_d     = state_q;
    tgt_d       = tgt_q;
    dwell_d     = dwell_q;
    timer_d     = timer_q;
    err_range_d = 1'b0;
    aborted_d   = 1'b0;
    step_en     = 1'b0;
    dir         = (tgt_q > count) ? DIR_UP : DIR_DOWN;
    next_count  = (dir == DIR_UP) ? count + 1'b1 : count - 1'b1;

    case (state_q)
      RAMP_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          // Clamp keeps the ramp from ever driving the counter into saturation.
          tgt_d       = (cmd_target > MAX_V) ? MAX_V : cmd_target;
          err_range_d = (cmd_target > MAX_V);
          dwell_d     = cmd_dwell;
          timer_d     = cmd_dwell;
          state_d     = (tgt_d == count) ? RAMP_DONE : RAMP_RUN;
        end
      end
      RAMP_RUN: begin
        if (abort) begin
          state_d   = RAMP_DONE;
          aborted_d = 1'b1;
        end else if (timer_q != '0) begin
          timer_d = timer_q - 1'b1;
        end else begin
          step_en = 1'b1;
          timer_d = dwell_q;
          if (next_count == tgt_q) state_d = RAMP_DONE;
        end
      end
      RAMP_DONE: state_d = RAMP_IDLE;
      default:   state_d = RAMP_IDLE;
    endcase

    cmd_ready_d = (state_d == RAMP_IDLE);
    busy_d      = (state_d != RAMP_IDLE);
    done_d      = (state_d == RAMP_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RAMP_IDLE;
      tgt_q       <= '0;
      dwell_q     <= '0;
      timer_q     <= '0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
      err_range_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      tgt_q       <= tgt_d;
      dwell_q     <= dwell_d;
      timer_q     <= timer_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      aborted_q   <= aborted_d;
      err_range_q <= err_range_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign aborted   = aborted_q;
  assign err_range = err_range_q;

endmodule

// File: tb/tb_counter_ramp_ctrl.sv
// Bench for counter_ramp_ctrl (MaxValue=200): directed table, random
// commands against an arithmetic ramp model, and reset corner sequences.
module tb_counter_ramp_ctrl;

  localparam int W    = 8;
  localparam int MAXV = 200;
  localparam int DW   = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [W-1:0]  cmd_target = '0;
  logic [DW-1:0] cmd_dwell = '0;
  logic          abort = 1'b0;
  logic [W-1:0]  count;
  logic          busy, done, aborted, err_range;

  int tests = 0;
  int fails = 0;
  int model_count = 0;

  counter_ramp_ctrl #(
    .Width      (W),
    .MaxValue   (MAXV),
    .DwellWidth (DW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_target (cmd_target),
    .cmd_dwell  (cmd_dwell),
    .abort      (abort),
    .count      (count),
    .busy       (busy),
    .done       (done),
    .aborted    (aborted),
    .err_range  (err_range)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Ramp model: with n steps of period (d+1), the ramp ends K=(d+1)*n edges
  // after accept; an abort on edge a keeps only the steps before it.
  task automatic run_cmd(input int tgt_in, input int d, input int abort_at,
                         output int done_k, output int fin,
                         output int seen_err, output int seen_ab);
    int start, tgt, n, kk, steps_total, steps, exp_cnt, ab_exp;
    start  = model_count;
    tgt    = (tgt_in > MAXV) ? MAXV : tgt_in;
    n      = (tgt > start) ? tgt - start : start - tgt;
    kk     = (d + 1) * n;
    ab_exp = 0;
    steps_total = n;
    if (abort_at > 0 && abort_at <= kk) begin
      ab_exp      = 1;
      kk          = abort_at;
      steps_total = (abort_at - 1) / (d + 1);
    end
    done_k = -1; seen_err = 0; seen_ab = 0; exp_cnt = start;
    chk("ready_before_cmd", int'(cmd_ready), 1);
    for (int k = 0; k <= kk + 1; k++) begin
      if (k == 0) begin
        cmd_valid  = 1'b1;
        cmd_target = W'(tgt_in);
        cmd_dwell  = DW'(d);
        abort      = 1'($urandom_range(0, 1));
      end else begin
        abort = (ab_exp != 0 && k == abort_at);
      end
      @(posedge clk);
      #1;
      if (k == 0) begin
        cmd_valid  = 1'b0;
        abort      = 1'b0;
        cmd_target = W'($urandom);
        cmd_dwell  = DW'($urandom);
      end
      steps   = (k / (d + 1) < steps_total) ? k / (d + 1) : steps_total;
      exp_cnt = (tgt >= start) ? start + steps : start - steps;
      if (done)      done_k   = k;
      if (err_range) seen_err = 1;
      if (aborted)   seen_ab  = 1;
      chk("count",     int'(count),     exp_cnt);
      chk("busy",      int'(busy),      int'(k <= kk));
      chk("done",      int'(done),      int'(k == kk));
      chk("aborted",   int'(aborted),   int'(k == kk && ab_exp != 0));
      chk("cmd_ready", int'(cmd_ready), int'(k > kk));
      chk("err_range", int'(err_range), int'(k == 0 && tgt_in > MAXV));
    end
    abort = 1'b0;
    fin = int'(count);
    model_count = exp_cnt;
    $display("[TB] cmd from=%0d target=%0d dwell=%0d abort_at=%0d -> count=%0d done_k=%0d err=%0d ab=%0d",
             start, tgt_in, d, abort_at, fin, done_k, seen_err, seen_ab);
  endtask

  typedef struct {
    int target;
    int dwell;
    int abort_at;
    int exp_final;
    int exp_done_k;
    int exp_err;
    int exp_aborted;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int dk, fin, se, sa, waited;

    vecs[0] = '{5,   0, 0,  5,   5,   0, 0};  // 0 -> 5 every cycle
    vecs[1] = '{2,   3, 0,  2,   12,  0, 0};  // 5 -> 2 every 4 cycles
    vecs[2] = '{2,   7, 0,  2,   0,   0, 0};  // already at target
    vecs[3] = '{250, 0, 0,  200, 198, 1, 0};  // clamped to MaxValue
    vecs[4] = '{190, 2, 0,  190, 30,  0, 0};  // 200 -> 190
    vecs[5] = '{200, 0, 4,  193, 4,   0, 1};  // abort beats 4th step
    vecs[6] = '{0,   0, 0,  0,   193, 0, 0};  // back down to 0
    vecs[7] = '{10,  1, 10, 4,   10,  0, 1};  // abort at count 4 on step edge

    // Asynchronous reset asserted mid-cycle.
    #12 rst = 1'b1;
    #2;
    chk("rst_count",     int'(count),     0);
    chk("rst_cmd_ready", int'(cmd_ready), 1);
    chk("rst_busy",      int'(busy),      0);
    chk("rst_done",      int'(done),      0);
    chk("rst_aborted",   int'(aborted),   0);
    chk("rst_err",       int'(err_range), 0);
    @(negedge clk) rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_count", int'(count), 0);
    chk("idle_busy",  int'(busy),  0);
    model_count = 0;

    for (int i = 0; i < 8; i++) begin
      run_cmd(vecs[i].target, vecs[i].dwell, vecs[i].abort_at, dk, fin, se, sa);
      chk("vec_final",   fin, vecs[i].exp_final);
      chk("vec_done_k",  dk,  vecs[i].exp_done_k);
      chk("vec_err",     se,  vecs[i].exp_err);
      chk("vec_aborted", sa,  vecs[i].exp_aborted);
    end

    // Reset in the middle of a ramp: count clears, no done pulse follows.
    cmd_valid = 1'b1; cmd_target = 8'd10; cmd_dwell = 8'd1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    waited = 0;
    while (count != 8'd6 && waited < 40) begin
      @(posedge clk);
      #1;
      waited++;
    end
    chk("midramp_reached_6", int'(count), 6);
    #3 rst = 1'b1;
    #1;
    chk("midrst_count", int'(count),     0);
    chk("midrst_busy",  int'(busy),      0);
    chk("midrst_ready", int'(cmd_ready), 1);
    chk("midrst_done",  int'(done),      0);
    @(negedge clk) rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      chk("post_rst_done",  int'(done),  0);
      chk("post_rst_count", int'(count), 0);
      chk("post_rst_busy",  int'(busy),  0);
    end
    $display("[TB] reset mid-ramp at count 6 -> count=%0d busy=%0d", count, busy);
    model_count = 0;

    for (int i = 0; i < 24; i++) begin
      int t, d, ab;
      t  = $urandom_range(0, 255);
      d  = $urandom_range(0, 3);
      ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 60) : 0;
      run_cmd(t, d, ab, dk, fin, se, sa);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
